fetch_decode_reg: RTL and testbench
===================================

# fetch_decode_reg

IF/ID boundary stage of the 16-bit pipeline. It sits directly downstream of the fetch stage and pairs each synchronous instruction-memory read with the program counter value that produced it. It presents a valid instruction to decode and implements stall, flush and halt. It also generates the fetch-stage control strobes: PC write enable, branch select and clock-counter enable.

## Interface
- NOP_INSN, 16'h0000, instruction word driven on id_instruction when no valid instruction is present
- HALT_INSN, 16'hC0F0, instruction word that stops the machine when it reaches ID
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- program_counter_pre  in  16  fetch stage's PC+1 for the address currently on the memory bus
- imem_data  in  16  synchronous instruction RAM read data (1-cycle latency, re-reads the held address every cycle)
- stall  in  1  hazard unit request to freeze fetch and ID
- flush  in  1  taken branch resolved downstream; kill all younger instructions
- op_pc_write  out  1  PC write enable to fetch
- op_branch  out  1  select branch_address in fetch
- op_cc_write  out  1  clock-counter enable to fetch
- id_valid  out  1  id_instruction/id_pc_pre hold a real instruction
- id_instruction  out  16  instruction to decode
- id_pc_pre  out  16  PC+1 of id_instruction
- halted  out  1  HALT state indicator

## Operation
- Pipeline registers:
  - f2_valid/f2_pc_pre: tag for the read in flight.
  - hold_valid/hold_insn: skid register.
  - ID register: id_valid, id_instruction, id_pc_pre.
- FSM states: RUN, HOLD, HALT. Reset state is RUN.
- Control outputs:
  - op_pc_write = reset & (state!=HALT) & (flush | ~stall).
  - op_branch = reset & flush & (state!=HALT).
  - op_cc_write = reset & (state!=HALT).
- RUN, no stall, no flush:
  - f2 <= {1, program_counter_pre}.
  - ID <= {f2_valid, imem_data, f2_pc_pre}.
- RUN, stall=1, flush=0:
  - f2 and ID hold.
  - If f2_valid: hold_insn <= imem_data, hold_valid <= 1, go to HOLD.
- HOLD, stall=1: all registers hold. imem_data is ignored because the RAM now returns the next address.
- HOLD, stall=0:
  - ID <= {1, hold_insn, f2_pc_pre}.
  - f2 <= {1, program_counter_pre}.
  - hold_valid <= 0, go to RUN.
- flush=1 in RUN or HOLD (priority over stall and halt):
  - f2_valid <= 0, id_valid <= 0, id_instruction <= NOP_INSN.
  - hold_valid <= 0, go to RUN.
- Halt: if id_valid and id_instruction==HALT_INSN, with no flush and no stall in that cycle:
  - Go to HALT at the edge.
  - id_valid <= 0, f2_valid <= 0, halted <= 1.
- HALT is exited only by reset. stall and flush are ignored there.
- id_valid=0 always implies id_instruction==NOP_INSN.

## Timing
- Reset low (asynchronous, immediate):
  - id_valid=0, id_instruction=NOP_INSN, id_pc_pre=0.
  - f2_valid=0, hold_valid=0, halted=0, state=RUN.
  - op_pc_write, op_branch and op_cc_write are 0 while reset is low.
- Fetch-to-ID latency:
  - Address presented in cycle n.
  - f2 tagged at edge n.
  - Instruction in ID after edge n+1.
- After reset release with PC=0, first id_valid=1 is the second cycle after release.
- op_pc_write and op_branch are combinational in the same cycle as stall/flush. A flush redirects the PC at the same edge that kills f2/ID.
- Each stall cycle freezes PC and ID for exactly that cycle.
  - No instruction is duplicated or dropped across any stall length ≥1.
  - A stall of length 1 passes through HOLD for one cycle.
- Stall while f2_valid=0 (e.g. directly after a flush): no capture, state stays RUN.
- The cycle counter counts every cycle up to and including the cycle where HALT_INSN sits in ID. op_cc_write=0 from the next cycle onward.
- id_pc_pre wraps: PC+1 of 16'hFFFF is 16'h0000. This is passed through unmodified.

## Test plan
- Reset release, RAM returns 16'h1000+addr, no stall or flush:
  - Two cycles later id_valid=1, id_instruction=16'h1000, id_pc_pre=1.
  - Then 16'h1001/2, 16'h1002/3 on consecutive cycles.
  - op_pc_write=1 throughout.
- Stall for 3 cycles while ID holds 16'h1002:
  - ID holds 16'h1002/3 for 3 cycles, op_pc_write=0.
  - After release ID gives 16'h1003/4, then 16'h1004/5; nothing skipped or repeated.
- Flush while ID holds 16'h1004, target 16'h0020:
  - op_pc_write=1, op_branch=1 that cycle.
  - Next 2 cycles id_valid=0, id_instruction=16'h0000.
  - Then 16'h1020 with id_pc_pre=16'h0021.
- Flush and stall asserted in the same cycle during HOLD:
  - Flush wins: op_pc_write=1, op_branch=1, hold_valid cleared, state RUN.
- HALT_INSN 16'hC0F0 at address 6:
  - When it is in ID, op_cc_write=1 that cycle.
  - From the next cycle: halted=1, id_valid=0, op_pc_write=0, op_cc_write=0.
  - Stays so under later stall/flush pulses until reset.
- Reset asserted mid-HOLD between clock edges:
  - All outputs take reset values immediately without a clock edge.
  - After release the sequence restarts from address 0.

Source files
------------

// File: rtl/fetch_decode_reg_if.sv
// Signal bundle between the fetch stage / instruction RAM and the IF/ID boundary register.
// master = fetch side driving the stage, slave = fetch_decode_reg itself.
interface fetch_decode_reg_if;
    logic [15:0] program_counter_pre;
    logic [15:0] imem_data;
    logic        stall;
    logic        flush;
    logic        op_pc_write;
    logic        op_branch;
    logic        op_cc_write;
    logic        id_valid;
    logic [15:0] id_instruction;
    logic [15:0] id_pc_pre;
    logic        halted;

    modport master (
        output program_counter_pre, imem_data, stall, flush,
        input  op_pc_write, op_branch, op_cc_write,
        input  id_valid, id_instruction, id_pc_pre, halted
    );

    modport slave (
        input  program_counter_pre, imem_data, stall, flush,
        output op_pc_write, op_branch, op_cc_write,
        output id_valid, id_instruction, id_pc_pre, halted
    );
endinterface

// File: rtl/fetch_decode_reg.sv
// IF/ID boundary: pairs each synchronous RAM read with its PC+1 tag, skids the read
// data across stalls, and handles flush and halt. Also drives the fetch control strobes.
module fetch_decode_reg (
    input  logic              clock,
    input  logic              reset,
    fetch_decode_reg_if.slave fd
);
    localparam logic [15:0] NOP_INSN  = 16'h0000;
    localparam logic [15:0] HALT_INSN = 16'hC0F0;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        f2_valid_q, f2_valid_d;
    logic [15:0] f2_pc_pre_q, f2_pc_pre_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] hold_insn_q, hold_insn_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] id_insn_q, id_insn_d;
    logic [15:0] id_pc_pre_q, id_pc_pre_d;
    logic        halted_q, halted_d;

    logic active_s;
    logic capture_s;
    logic halt_hit_s;

    assign active_s   = (state_q != ST_HALT);
    // Only RUN captures: in HOLD the RAM already returns the address after the one in f2.
    assign capture_s  = (state_q == ST_RUN) && f2_valid_q;
    assign halt_hit_s = id_valid_q && (id_insn_q == HALT_INSN);

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: flush beats stall beats halt
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_HOLD: begin
                if (fd.flush) begin
                    state_d = ST_RUN;
                end else if (fd.stall) begin
                    state_d = capture_s ? ST_HOLD : state_q;
                end else if (halt_hit_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: fetch strobes react combinationally to stall/flush in the same cycle
    always_comb begin
        fd.op_pc_write = reset & active_s & (fd.flush | ~fd.stall);
        fd.op_branch   = reset & active_s & fd.flush;
        fd.op_cc_write = reset & active_s;
    end

    // Pipeline register next values
    always_comb begin
        f2_valid_d   = f2_valid_q;
        f2_pc_pre_d  = f2_pc_pre_q;
        hold_valid_d = hold_valid_q;
        hold_insn_d  = hold_insn_q;
        id_valid_d   = id_valid_q;
        id_insn_d    = id_insn_q;
        id_pc_pre_d  = id_pc_pre_q;
        halted_d     = halted_q;
        if (state_q == ST_HALT) begin
            halted_d = 1'b1;
        end else if (fd.flush) begin
            f2_valid_d   = 1'b0;
            id_valid_d   = 1'b0;
            id_insn_d    = NOP_INSN;
            hold_valid_d = 1'b0;
        end else if (fd.stall) begin
            if (capture_s) begin
                hold_insn_d  = fd.imem_data;
                hold_valid_d = 1'b1;
            end else begin
                hold_insn_d  = hold_insn_q;
            end
        end else if (halt_hit_s) begin
            id_valid_d   = 1'b0;
            id_insn_d    = NOP_INSN;
            f2_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            halted_d     = 1'b1;
        end else if (state_q == ST_HOLD) begin
            id_valid_d   = hold_valid_q;
            id_insn_d    = hold_valid_q ? hold_insn_q : NOP_INSN;
            id_pc_pre_d  = f2_pc_pre_q;
            f2_valid_d   = 1'b1;
            f2_pc_pre_d  = fd.program_counter_pre;
            hold_valid_d = 1'b0;
        end else begin
            // Invalid f2 must still present a NOP so id_valid=0 always means NOP_INSN.
            id_valid_d   = f2_valid_q;
            id_insn_d    = f2_valid_q ? fd.imem_data : NOP_INSN;
            id_pc_pre_d  = f2_pc_pre_q;
            f2_valid_d   = 1'b1;
            f2_pc_pre_d  = fd.program_counter_pre;
        end
    end

    // Pipeline registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            f2_valid_q   <= 1'b0;
            f2_pc_pre_q  <= 16'h0000;
            hold_valid_q <= 1'b0;
            hold_insn_q  <= 16'h0000;
            id_valid_q   <= 1'b0;
            id_insn_q    <= NOP_INSN;
            id_pc_pre_q  <= 16'h0000;
            halted_q     <= 1'b0;
        end else begin
            f2_valid_q   <= f2_valid_d;
            f2_pc_pre_q  <= f2_pc_pre_d;
            hold_valid_q <= hold_valid_d;
            hold_insn_q  <= hold_insn_d;
            id_valid_q   <= id_valid_d;
            id_insn_q    <= id_insn_d;
            id_pc_pre_q  <= id_pc_pre_d;
            halted_q     <= halted_d;
        end
    end

    assign fd.id_valid       = id_valid_q;
    assign fd.id_instruction = id_insn_q;
    assign fd.id_pc_pre      = id_pc_pre_q;
    assign fd.halted         = halted_q;
endmodule

// File: tb/tb_fetch_decode_reg.sv
// Bench for fetch_decode_reg: a fetch/RAM model plus an address-level pipeline model
// (stall freezes everything, flush kills, halt stops) checked every negedge, with literal pins.
module tb_fetch_decode_reg;
    localparam logic [15:0] NOP_INSN  = 16'h0000;
    localparam logic [15:0] HALT_INSN = 16'hC0F0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] target = 16'h0000;

    fetch_decode_reg_if ifc();

    fetch_decode_reg dut (
        .clock (clock),
        .reset (reset),
        .fd    (ifc)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Program image: HALT at address 6, otherwise 16'h1000 + address.
    function automatic logic [15:0] mem(input logic [15:0] a);
        return (a == 16'd6) ? HALT_INSN : (16'h1000 + a);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Fetch stage and RAM model plus abstract pipeline: addresses in flight and in ID.
    logic [15:0] pc_q, ram_q;
    logic        m_f_v, m_id_v, m_halted;
    logic [15:0] m_f_a, m_id_a;
    logic        exp_pc_write, exp_branch, exp_cc;

    assign ifc.program_counter_pre = pc_q + 16'd1;
    assign ifc.imem_data           = ram_q;
    assign exp_pc_write = reset & ~m_halted & (ifc.flush | ~ifc.stall);
    assign exp_branch   = reset & ~m_halted & ifc.flush;
    assign exp_cc       = reset & ~m_halted;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= 16'd0; ram_q <= 16'd0;
            m_f_v <= 1'b0; m_f_a <= 16'd0; m_id_v <= 1'b0; m_id_a <= 16'd0; m_halted <= 1'b0;
        end else begin
            ram_q <= mem(pc_q);
            if (exp_pc_write) pc_q <= ifc.flush ? target : pc_q + 16'd1;
            if (m_halted) begin
                m_halted <= 1'b1;
            end else if (ifc.flush) begin
                m_f_v <= 1'b0; m_id_v <= 1'b0;
            end else if (ifc.stall) begin
                m_f_v <= m_f_v;
            end else if (m_id_v && mem(m_id_a) == HALT_INSN) begin
                m_halted <= 1'b1; m_id_v <= 1'b0; m_f_v <= 1'b0;
            end else begin
                m_id_v <= m_f_v; m_id_a <= m_f_a;
                m_f_v  <= 1'b1;  m_f_a  <= pc_q;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        chk("id_valid", {15'd0, ifc.id_valid}, {15'd0, m_id_v});
        chk("id_instruction", ifc.id_instruction, m_id_v ? mem(m_id_a) : NOP_INSN);
        if (m_id_v) chk("id_pc_pre", ifc.id_pc_pre, m_id_a + 16'd1);
        chk("halted", {15'd0, ifc.halted}, {15'd0, m_halted});
        chk("op_pc_write", {15'd0, ifc.op_pc_write}, {15'd0, exp_pc_write});
        chk("op_branch", {15'd0, ifc.op_branch}, {15'd0, exp_branch});
        chk("op_cc_write", {15'd0, ifc.op_cc_write}, {15'd0, exp_cc});
    end

    task automatic drive(input logic s, input logic f, input logic [15:0] t);
        ifc.stall = s; ifc.flush = f; target = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_id(input string name, input logic v, input logic [15:0] insn, input logic [15:0] pcp);
        chk({name, "_valid"}, {15'd0, ifc.id_valid}, {15'd0, v});
        chk({name, "_insn"}, ifc.id_instruction, insn);
        if (v) chk({name, "_pcpre"}, ifc.id_pc_pre, pcp);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_valid"}, {15'd0, ifc.id_valid}, 16'd0);
        chk({name, "_insn"}, ifc.id_instruction, 16'h0000);
        chk({name, "_pcpre"}, ifc.id_pc_pre, 16'h0000);
        chk({name, "_halted"}, {15'd0, ifc.halted}, 16'd0);
        chk({name, "_pcw"}, {15'd0, ifc.op_pc_write}, 16'd0);
        chk({name, "_br"}, {15'd0, ifc.op_branch}, 16'd0);
        chk({name, "_cc"}, {15'd0, ifc.op_cc_write}, 16'd0);
    endtask

    initial begin
        ifc.stall = 1'b0; ifc.flush = 1'b0;
        #1;
        chk_reset_vals("por");
        tick(); tick();
        reset = 1'b1;                                   // release: PC=0 on the bus
        drive(1'b0, 1'b0, 16'h0000);
        chk("run_pcw", {15'd0, ifc.op_pc_write}, 16'd1);
        chk_id("rel0", 1'b0, 16'h0000, 16'h0000);
        tick();
        chk_id("rel1", 1'b0, 16'h0000, 16'h0000);
        tick();
        chk_id("first", 1'b1, 16'h1000, 16'h0001);
        tick();
        chk_id("second", 1'b1, 16'h1001, 16'h0002);
        tick();
        chk_id("third", 1'b1, 16'h1002, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h0000);
            chk_id("stall3", 1'b1, 16'h1002, 16'h0003);
            chk("stall3_pcw", {15'd0, ifc.op_pc_write}, 16'd0);
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000);
        chk_id("unstall", 1'b1, 16'h1002, 16'h0003);
        tick();
        chk_id("after3", 1'b1, 16'h1003, 16'h0004);
        tick();
        chk_id("after4", 1'b1, 16'h1004, 16'h0005);
        drive(1'b0, 1'b1, 16'h0020);                    // flush to 0x0020
        chk("flush_pcw", {15'd0, ifc.op_pc_write}, 16'd1);
        chk("flush_br", {15'd0, ifc.op_branch}, 16'd1);
        tick();
        drive(1'b0, 1'b0, 16'h0000);
        chk_id("bubble1", 1'b0, 16'h0000, 16'h0000);
        tick();
        chk_id("bubble2", 1'b0, 16'h0000, 16'h0000);
        tick();
        chk_id("target", 1'b1, 16'h1020, 16'h0021);
        tick(); tick();
        drive(1'b1, 1'b0, 16'h0000);                    // single-cycle stall through HOLD
        tick();
        drive(1'b0, 1'b0, 16'h0000);
        chk_id("hold1", 1'b1, 16'h1022, 16'h0023);
        tick();
        chk_id("hold1_out", 1'b1, 16'h1023, 16'h0024);
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        drive(1'b1, 1'b1, 16'h0040);                    // flush + stall while in HOLD
        chk("hflush_pcw", {15'd0, ifc.op_pc_write}, 16'd1);
        chk("hflush_br", {15'd0, ifc.op_branch}, 16'd1);
        tick();
        drive(1'b1, 1'b0, 16'h0000);                    // stall with nothing in flight
        chk("nocap_pcw", {15'd0, ifc.op_pc_write}, 16'd0);
        chk_id("nocap", 1'b0, 16'h0000, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 16'h0000);
        tick(); tick();
        chk_id("tgt40", 1'b1, 16'h1040, 16'h0041);
        tick();
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        drive(1'b1, 1'b0, 16'h0000);                    // now in HOLD
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("midhold");
        drive(1'b0, 1'b0, 16'h0000);
        tick(); tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        tick(); tick();
        chk_id("restart", 1'b1, 16'h1000, 16'h0001);
        for (int i = 0; i < 6; i++) tick();
        chk_id("haltid", 1'b1, HALT_INSN, 16'h0007);
        chk("haltid_cc", {15'd0, ifc.op_cc_write}, 16'd1);
        chk("haltid_h", {15'd0, ifc.halted}, 16'd0);
        tick();
        chk_id("halted", 1'b0, 16'h0000, 16'h0000);
        chk("halted_h", {15'd0, ifc.halted}, 16'd1);
        chk("halted_pcw", {15'd0, ifc.op_pc_write}, 16'd0);
        chk("halted_cc", {15'd0, ifc.op_cc_write}, 16'd0);
        drive(1'b1, 1'b0, 16'h0000); tick();
        drive(1'b0, 1'b1, 16'h0010);
        chk("hflsh_pcw", {15'd0, ifc.op_pc_write}, 16'd0);
        chk("hflsh_br", {15'd0, ifc.op_branch}, 16'd0);
        tick();
        drive(1'b1, 1'b1, 16'h0010); tick();
        drive(1'b0, 1'b0, 16'h0000); tick();
        chk("stay_h", {15'd0, ifc.halted}, 16'd1);
        chk_id("stay", 1'b0, 16'h0000, 16'h0000);
        chk("stay_cc", {15'd0, ifc.op_cc_write}, 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
